// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller: baud generator, frame-config shadow, receive FIFO
// Shadowed config only reloads between frames so the receiver never sees a mid-frame change.
module uart_rx_ctrl #(
    parameter int DIV_W = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DIV_W-1:0]         cfg_baud_div,
    input  logic                     cfg_data_size,
    input  logic                     cfg_parity_en,
    input  logic                     cfg_stop_bit_size,
    input  logic [1:0]               cfg_parity_mode,
    output logic                     clk_uart,
    input  logic                     uart_enable,
    output logic                     data_size,
    output logic                     parity_en,
    output logic                     stop_bit_size,
    output logic [1:0]               parity_mode,
    input  logic [7:0]               rx_data,
    input  logic                     rx_error_parity,
    input  logic                     rx_error_frame,
    input  logic                     rx_ready,
    input  logic                     rx_newData,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [7:0]               rd_data,
    output logic                     rd_perr,
    output logic                     rd_ferr,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    input  logic                     overflow_clr
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DIV_W-1:0] baud_div_q;
    logic             data_size_q, parity_en_q, stop_bit_size_q;
    logic [1:0]       parity_mode_q;
    logic             load_cfg;

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             clk_uart_q, clk_uart_d;

    logic [9:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, push, pop, ovf_set;
    logic [9:0]       head;

    assign load_cfg = rx_ready & ~uart_enable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_div_q      <= '0;
            data_size_q     <= 1'b0;
            parity_en_q     <= 1'b0;
            stop_bit_size_q <= 1'b0;
            parity_mode_q   <= 2'b00;
        end else if (load_cfg) begin
            baud_div_q      <= cfg_baud_div;
            data_size_q     <= cfg_data_size;
            parity_en_q     <= cfg_parity_en;
            stop_bit_size_q <= cfg_stop_bit_size;
            parity_mode_q   <= cfg_parity_mode;
        end
    end

    // Each half bit lasts baud_div+1 cycles; the counter restarts from 0 on every enable.
    always_comb begin
        cnt_d      = cnt_q;
        clk_uart_d = clk_uart_q;
        if (!uart_enable) begin
            cnt_d      = '0;
            clk_uart_d = 1'b0;
        end else if (cnt_q == baud_div_q) begin
            cnt_d      = '0;
            clk_uart_d = ~clk_uart_q;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            clk_uart_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            clk_uart_q <= clk_uart_d;
        end
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    always_comb begin
        full     = (count_q == CNT_W'(DEPTH));
        pop      = (count_q != '0) & rd_ready;
        push     = rx_newData & (~full | pop);
        ovf_set  = rx_newData & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        ovf_d = ovf_set | (ovf_q & ~overflow_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {rx_error_frame, rx_error_parity, rx_data};
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign rd_data       = head[7:0];
    assign rd_perr       = head[8];
    assign rd_ferr       = head[9];
    assign rd_valid      = (count_q != '0);
    assign fifo_count    = count_q;
    assign overflow      = ovf_q;
    assign clk_uart      = clk_uart_q;
    assign data_size     = data_size_q;
    assign parity_en     = parity_en_q;
    assign stop_bit_size = stop_bit_size_q;
    assign parity_mode   = parity_mode_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - self-checking bench for uart_rx_ctrl against a queue-based reference model
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] cfg_baud_div = '0;
    logic        cfg_data_size = 1'b0, cfg_parity_en = 1'b0, cfg_stop_bit_size = 1'b0;
    logic [1:0]  cfg_parity_mode = 2'b00;
    logic        clk_uart;
    logic        uart_enable = 1'b0;
    logic        data_size, parity_en, stop_bit_size;
    logic [1:0]  parity_mode;
    logic [7:0]  rx_data = '0;
    logic        rx_error_parity = 1'b0, rx_error_frame = 1'b0, rx_ready = 1'b0, rx_newData = 1'b0;
    logic        rd_valid;
    logic        rd_ready = 1'b0;
    logic [7:0]  rd_data;
    logic        rd_perr, rd_ferr;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        overflow_clr = 1'b0;

    uart_rx_ctrl #(.DIV_W(16), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_baud_div(cfg_baud_div), .cfg_data_size(cfg_data_size),
        .cfg_parity_en(cfg_parity_en), .cfg_stop_bit_size(cfg_stop_bit_size),
        .cfg_parity_mode(cfg_parity_mode),
        .clk_uart(clk_uart), .uart_enable(uart_enable),
        .data_size(data_size), .parity_en(parity_en),
        .stop_bit_size(stop_bit_size), .parity_mode(parity_mode),
        .rx_data(rx_data), .rx_error_parity(rx_error_parity),
        .rx_error_frame(rx_error_frame), .rx_ready(rx_ready), .rx_newData(rx_newData),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_perr(rd_perr), .rd_ferr(rd_ferr),
        .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    int vec  = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: bit clock from elapsed enabled cycles, FIFO as a queue.
    logic [15:0] m_div;
    logic        m_ds, m_pe, m_sb, m_clk, m_ovf, m_set, m_pop;
    logic [1:0]  m_pm;
    int          m_en_cnt;
    logic [9:0]  m_q [$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_div = '0; m_ds = 1'b0; m_pe = 1'b0; m_sb = 1'b0; m_pm = 2'b00;
            m_en_cnt = 0; m_clk = 1'b0; m_ovf = 1'b0;
            m_q.delete();
        end else begin
            if (uart_enable) begin
                m_en_cnt++;
                m_clk = ((m_en_cnt / (int'(m_div) + 1)) % 2) == 1;
            end else begin
                m_en_cnt = 0;
                m_clk = 1'b0;
            end
            if (rx_ready && !uart_enable) begin
                m_div = cfg_baud_div; m_ds = cfg_data_size; m_pe = cfg_parity_en;
                m_sb = cfg_stop_bit_size; m_pm = cfg_parity_mode;
            end
            m_pop = (m_q.size() != 0) && rd_ready;
            m_set = 1'b0;
            if (m_pop) void'(m_q.pop_front());
            if (rx_newData) begin
                if (m_q.size() < DEPTH) m_q.push_back({rx_error_frame, rx_error_parity, rx_data});
                else m_set = 1'b1;
            end
            if (m_set) m_ovf = 1'b1;
            else if (overflow_clr) m_ovf = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            chk("clk_uart", clk_uart, m_clk);
            chk("data_size", data_size, m_ds);
            chk("parity_en", parity_en, m_pe);
            chk("stop_bit_size", stop_bit_size, m_sb);
            chk("parity_mode", parity_mode, m_pm);
            chk("rd_valid", rd_valid, m_q.size() != 0);
            chk("fifo_count", fifo_count, m_q.size());
            chk("overflow", overflow, m_ovf);
            if (m_q.size() != 0) begin
                chk("rd_data", rd_data, m_q[0][7:0]);
                chk("rd_perr", rd_perr, m_q[0][8]);
                chk("rd_ferr", rd_ferr, m_q[0][9]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic measure(output int first, output int period);
        int   n = 0, r1 = -1, r2 = -1;
        logic prev;
        prev = clk_uart;
        while (r2 < 0 && n < 200) begin
            cyc();
            n++;
            if (!prev && clk_uart) begin
                if (r1 < 0) r1 = n;
                else r2 = n;
            end
            prev = clk_uart;
        end
        first  = r1;
        period = (r2 < 0) ? -1 : r2 - r1;
    endtask

    task automatic push(input logic [7:0] d);
        rx_data = d; rx_newData = 1'b1;
        cyc();
        rx_newData = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int f, p, n;
        logic [7:0] exp_d [4];

        repeat (3) @(posedge clk);
        #2;
        chk("rst_clk_uart", clk_uart, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_cfg", {data_size, parity_en, stop_bit_size, parity_mode}, 0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        cfg_baud_div = 16'd3; rx_ready = 1'b1;
        cyc(); cyc();
        uart_enable = 1'b1; rx_ready = 1'b0;
        measure(f, p);
        chk("first_rise_div3", f, 4);
        chk("period_div3", p, 8);
        cfg_baud_div = 16'd9;
        measure(f, p);
        chk("period_held_mid_frame", p, 8);
        uart_enable = 1'b0;
        cyc();
        chk("clk_uart_drop", clk_uart, 0);
        rx_ready = 1'b1;
        cyc();
        uart_enable = 1'b1; rx_ready = 1'b0;
        measure(f, p);
        chk("first_rise_div9", f, 10);
        chk("period_div9", p, 20);
        uart_enable = 1'b0;
        cyc();

        rd_ready = 1'b0;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        chk("full_count", fifo_count, 4);
        chk("full_no_ovf", overflow, 0);
        push(8'h55);
        chk("ovf_set", overflow, 1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_head", rd_data, 8'h11);
        rx_data = 8'h66; rx_newData = 1'b1; rd_ready = 1'b1;
        cyc();
        rx_newData = 1'b0; rd_ready = 1'b0;
        chk("pushpop_count", fifo_count, 4);
        chk("pushpop_ovf", overflow, 1);
        exp_d[0] = 8'h22; exp_d[1] = 8'h33; exp_d[2] = 8'h44; exp_d[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", rd_data, exp_d[i]);
            rd_ready = 1'b1;
            cyc();
            rd_ready = 1'b0;
        end
        chk("drained_valid", rd_valid, 0);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;
        chk("empty_pop_count", fifo_count, 0);
        overflow_clr = 1'b1;
        cyc();
        overflow_clr = 1'b0;
        chk("ovf_clr", overflow, 0);

        for (int i = 0; i < 4; i++) push(8'(i));
        rx_newData = 1'b1; overflow_clr = 1'b1;
        cyc();
        rx_newData = 1'b0; overflow_clr = 1'b0;
        chk("set_beats_clr", overflow, 1);
        overflow_clr = 1'b1; rd_ready = 1'b1;
        repeat (4) cyc();
        overflow_clr = 1'b0; rd_ready = 1'b0;

        rx_error_frame = 1'b1; rx_error_parity = 1'b0;
        push(8'hA5);
        rx_error_frame = 1'b0;
        chk("err_data", rd_data, 8'hA5);
        chk("err_ferr", rd_ferr, 1);
        chk("err_perr", rd_perr, 0);
        rd_ready = 1'b1;
        cyc();
        rd_ready = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) uart_enable = ~uart_enable;
            rx_ready          = 1'($urandom_range(0, 1));
            cfg_baud_div      = 16'($urandom_range(0, 4));
            cfg_data_size     = 1'($urandom_range(0, 1));
            cfg_parity_en     = 1'($urandom_range(0, 1));
            cfg_stop_bit_size = 1'($urandom_range(0, 1));
            cfg_parity_mode   = 2'($urandom_range(0, 3));
            rx_newData        = ($urandom_range(0, 9) < 4);
            rx_data           = 8'($urandom);
            rx_error_parity   = 1'($urandom_range(0, 1));
            rx_error_frame    = 1'($urandom_range(0, 1));
            rd_ready          = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            overflow_clr      = ($urandom_range(0, 15) == 0);
            cyc();
        end
        rx_newData = 1'b0; rd_ready = 1'b0; overflow_clr = 1'b0;

        uart_enable = 1'b0; rx_ready = 1'b1;
        cfg_baud_div = 16'd1; cfg_data_size = 1'b1;
        cyc();
        rx_ready = 1'b0; uart_enable = 1'b1;
        rd_ready = 1'b1;
        repeat (4) cyc();
        rd_ready = 1'b0;
        push(8'h5A); push(8'hC3);
        n = 0;
        while (!clk_uart && n < 20) begin
            cyc();
            n++;
        end
        chk("pre_rst_clk_uart", clk_uart, 1);
        chk("pre_rst_count", fifo_count, 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_uart", clk_uart, 0);
        chk("async_rst_rd_valid", rd_valid, 0);
        chk("async_rst_count", fifo_count, 0);
        chk("async_rst_data_size", data_size, 0);
        uart_enable = 1'b0;
        repeat (2) cyc();
        rst_n = 1'b1;
        repeat (3) cyc();
        chk("post_rst_count", fifo_count, 0);
        chk("post_rst_valid", rd_valid, 0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the baud divider.
REQ-002 SHALL have parameter DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single system clock; all registers clocked on its rising edge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_baud_div  in  DIV_W  host baud divider; half UART bit = cfg_baud_div+1 clk cycles.
REQ-006 SHALL have port cfg_data_size, cfg_parity_en, cfg_stop_bit_size  in  1 each  host frame config.
REQ-007 SHALL have port cfg_parity_mode  in  2  host parity mode.
REQ-008 SHALL have port clk_uart  out  1  UART bit clock to the receiver.
REQ-009 SHALL have port uart_enable  in  1  bit-clock request from the receiver.
REQ-010 SHALL have ports data_size, parity_en, stop_bit_size (out, 1 each) and parity_mode (out, 2)  shadowed config to the receiver.
REQ-011 SHALL have ports rx_data (in, 8), rx_error_parity (in, 1), rx_error_frame (in, 1), rx_ready (in, 1), rx_newData (in, 1)  receiver status.
REQ-012 SHALL have ports rd_valid (out, 1), rd_ready (in, 1), rd_data (out, 8), rd_perr (out, 1), rd_ferr (out, 1)  host read stream.
REQ-013 SHALL have ports fifo_count (out, log2(DEPTH)+1), overflow (out, 1, sticky), overflow_clr (in, 1).

Function
REQ-014 Baud generator SHALL hold divider counter at 0 and clk_uart low while uart_enable=0.
REQ-015 While uart_enable=1, the counter SHALL count 0..shadow baud_div; at terminal count it SHALL wrap to 0 and toggle clk_uart, giving period 2*(baud_div+1) cycles, first rising edge baud_div+1 cycles after enable.
REQ-016 Dropping uart_enable mid-period SHALL force counter 0 and clk_uart 0 on the next clock.
REQ-017 Shadow registers (baud_div, data_size, parity_en, parity_mode, stop_bit_size) SHALL load from cfg_* on every clock where rx_ready=1 and uart_enable=0; otherwise hold, so config never changes within a frame.
REQ-018 On rx_newData=1, the entry {rx_error_frame, rx_error_parity, rx_data} SHALL be written to the FIFO tail that cycle if not full.
REQ-019 Write while full SHALL drop the entry, set overflow; FIFO contents unchanged.
REQ-020 rd_valid SHALL equal (fifo_count!=0); rd_data/rd_perr/rd_ferr SHALL show the head entry combinationally from storage.
REQ-021 Pop SHALL occur when rd_valid & rd_ready; head advances next cycle.
REQ-022 Simultaneous push and pop SHALL both occur, count unchanged; when full, simultaneous push+pop SHALL succeed without overflow.
REQ-023 Pointers SHALL wrap modulo DEPTH; fifo_count SHALL range 0..DEPTH.
REQ-024 rd_data etc. SHALL hold stable while rd_valid & ~rd_ready.
REQ-025 overflow SHALL clear on overflow_clr=1; set in the same cycle as clear SHALL win (overflow=1).
REQ-026 rd_ready with rd_valid=0 SHALL have no effect.

Reset
REQ-027 rst_n=0 SHALL asynchronously force: clk_uart=0, divider=0, FIFO pointers/count=0, rd_valid=0, overflow=0.
REQ-028 Reset SHALL load shadow baud_div=0 and config outputs=0 (7 bit, no parity, space, 1 stop); first rx_ready after release reloads cfg_*.
REQ-029 Reset asserted mid-frame SHALL discard all FIFO contents and stop clk_uart immediately; no partial entry written after release.

Verification
REQ-030 cfg_baud_div=3, uart_enable rises -> clk_uart rises 4 cycles later, period 8 cycles; uart_enable falls -> clk_uart 0 next cycle.
REQ-031 cfg_baud_div changed 3->9 while uart_enable=1 -> period stays 8 until frame ends; after rx_ready=1, uart_enable=0, next frame period 20.
REQ-032 Four rx_newData pulses with data 0x11,0x22,0x33,0x44 (errors 0), rd_ready=0 -> fifo_count=4; fifth 0x55 -> overflow=1, count 4; drain -> 0x11..0x44 in order.
REQ-033 Full FIFO, rx_newData with 0x66 and rd_ready=1 same cycle -> 0x11 popped, 0x66 stored, overflow unchanged, count 4.
REQ-034 rx_newData with rx_data=0xA5, rx_error_frame=1, rx_error_parity=0 -> rd_data=0xA5, rd_ferr=1, rd_perr=0.
REQ-035 rst_n low with 2 entries and clk_uart high -> clk_uart=0, rd_valid=0, fifo_count=0 before next clk edge.
